// File: rtl/oled_char_render_pkg.sv
// oled_char_render shared package
// SSD1306 opcodes, font geometry and sequencer state encoding.
package oled_pkg;

  localparam logic [7:0] OLED_CMD_PAGE   = 8'hB0;
  localparam logic [7:0] OLED_CMD_COL_LO = 8'h00;
  localparam logic [7:0] OLED_CMD_COL_HI = 8'h10;

  localparam logic [5:0] FONT_SEL_MAX = 6'd14;

  // bit n set => glyph id n is 16 columns wide
  localparam logic [14:0] FONT_WIDE_MASK = 15'h0BF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_FETCH,
    ST_SEND
  } state_t;

  function automatic logic [3:0] glyph_last(
    input logic [5:0] sel
  );
    logic [15:0] m;
    logic        wide;
    m    = {1'b0, FONT_WIDE_MASK};
    wide = (sel <= FONT_SEL_MAX) && m[sel[3:0]];
    return wide ? 4'd15 : 4'd7;
  endfunction

endpackage

// File: rtl/oled_char_render_if.sv
// oled_char_render bus bundle
// Request, font ROM lookup and byte stream signals.
interface oled_char_render_if;

  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_font_sel;
  logic [2:0] req_page;
  logic [6:0] req_col;

  logic [5:0] font_sel;
  logic       font_row;
  logic [8:0] index;
  logic [7:0] font_data;

  logic       out_valid;
  logic       out_ready;
  logic       out_dc;
  logic [7:0] out_byte;

  logic       busy;
  logic       done;

  modport slave (
    input  req_valid,
    input  req_font_sel,
    input  req_page,
    input  req_col,
    input  font_data,
    input  out_ready,
    output req_ready,
    output font_sel,
    output font_row,
    output index,
    output out_valid,
    output out_dc,
    output out_byte,
    output busy,
    output done
  );

  modport master (
    output req_valid,
    output req_font_sel,
    output req_page,
    output req_col,
    output font_data,
    output out_ready,
    input  req_ready,
    input  font_sel,
    input  font_row,
    input  index,
    input  out_valid,
    input  out_dc,
    input  out_byte,
    input  busy,
    input  done
  );

endinterface

// File: rtl/oled_char_render.sv
// Character render sequencer: glyph request in,
// SSD1306 page-mode command and column bytes out.
module oled_char_render
  import oled_pkg::*;
(
  input  logic               sys_clk,
  input  logic               rst_n,
  oled_char_render_if.slave  bus
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_sel;
  logic [2:0] r_page;
  logic [6:0] r_col;
  logic       r_row;
  logic [3:0] r_idx;
  logic [1:0] r_cmd;
  logic       r_done;

  logic       w_accept;
  logic       w_valid;
  logic       w_fire;
  logic       w_last_col;
  logic       w_blank;
  logic [3:0] w_last;
  logic [2:0] w_pg;
  logic       w_dc;
  logic [7:0] w_byte;

  assign w_accept   = bus.req_valid
                   && (r_state == ST_IDLE);
  assign w_valid    = (r_state == ST_CMD)
                   || (r_state == ST_SEND);
  assign w_fire     = w_valid && bus.out_ready;
  assign w_last     = glyph_last(r_sel);
  assign w_last_col = (r_idx == w_last);
  assign w_blank    = (r_sel > FONT_SEL_MAX);
  // lower half lands on the next page, 3-bit wrap
  assign w_pg       = r_page + {2'b00, r_row};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_dc   = 1'b0;
    w_byte = 8'h00;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_CMD;
      end
      ST_CMD: begin
        unique case (r_cmd)
          2'd0:
            w_byte = OLED_CMD_PAGE
                   | {5'b0, w_pg};
          2'd1:
            w_byte = OLED_CMD_COL_LO
                   | {4'b0, r_col[3:0]};
          default:
            w_byte = OLED_CMD_COL_HI
                   | {5'b0, r_col[6:4]};
        endcase
        if (w_fire && (r_cmd == 2'd2))
          w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_next = ST_SEND;
      end
      ST_SEND: begin
        w_dc   = 1'b1;
        // ROM output stays valid while index is held
        w_byte = w_blank ? 8'h00 : bus.font_data;
        if (w_fire) begin
          if (!w_last_col)  w_next = ST_FETCH;
          else if (!r_row)  w_next = ST_CMD;
          else              w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= '0;
      r_page <= '0;
      r_col  <= '0;
      r_row  <= 1'b0;
      r_idx  <= '0;
      r_cmd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel  <= bus.req_font_sel;
            r_page <= bus.req_page;
            r_col  <= bus.req_col;
            r_row  <= 1'b0;
            r_idx  <= '0;
            r_cmd  <= '0;
          end
        end
        ST_CMD: begin
          if (w_fire)
            r_cmd <= (r_cmd == 2'd2)
                   ? 2'd0 : r_cmd + 2'd1;
        end
        ST_SEND: begin
          if (w_fire) begin
            if (!w_last_col) begin
              r_idx <= r_idx + 4'd1;
            end else if (!r_row) begin
              r_row <= 1'b1;
              r_idx <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.font_sel  = r_sel;
  assign bus.font_row  = r_row;
  assign bus.index     = {5'b0, r_idx};
  assign bus.out_valid = w_valid;
  assign bus.out_dc    = w_dc;
  assign bus.out_byte  = w_byte;

endmodule

// File: tb/tb_oled_char_render.sv
// Self-checking bench for oled_char_render
// with a registered font ROM model alongside.
module tb_oled_char_render;

  logic sys_clk = 1'b0;
  logic rst_n;

  oled_char_render_if bus();

  oled_char_render dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cyc;
  logic [8:0] cap_q[$];
  logic [8:0] exp_q[$];

  function automatic logic [7:0] rom(
    input logic [5:0] s,
    input logic       r,
    input logic [8:0] i
  );
    logic [7:0] v;
    v = 8'((int'(s) * 37 + int'(r) * 101
          + int'(i) * 13 + 5) & 255);
    if (s == 6'd0) begin
      case ({r, i[2:0]})
        4'h0: v = 8'h08;
        4'h1: v = 8'hF8;
        4'h2: v = 8'h88;
        4'h3: v = 8'h88;
        4'h4: v = 8'hE8;
        4'h5: v = 8'h08;
        4'h6: v = 8'h10;
        4'h8: v = 8'h20;
        4'h9: v = 8'h3F;
        4'hA: v = 8'h20;
        4'hC: v = 8'h03;
        default: v = 8'h00;
      endcase
    end else if (s == 6'd11) begin
      if (!r && i == 9'd0) v = 8'h06;
      else if (!r && i == 9'd1) v = 8'h09;
      else if (!r && i == 9'd2) v = 8'h09;
      else if (!r && i == 9'd3) v = 8'hE6;
      else if (r && i == 9'd13) v = 8'h10;
      else if (r && i >= 9'd14) v = 8'h00;
    end
    return v;
  endfunction

  // font ROM: registered, one-cycle latency
  always @(posedge sys_clk)
    bus.font_data <= rom(bus.font_sel,
                         bus.font_row, bus.index);

  task automatic check(
    input string       nm,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic int width_of(
    input logic [5:0] s
  );
    if (s == 6'd11 || (s >= 6'd4 && s <= 6'd9))
      return 16;
    return 8;
  endfunction

  // Reference stream from the drawing rules.
  task automatic model(
    input logic [5:0] s,
    input logic [2:0] p,
    input logic [6:0] c
  );
    int w;
    w = width_of(s);
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({1'b0,
        8'hB0 + 8'((int'(p) + r) % 8)});
      exp_q.push_back({1'b0, 8'(int'(c) % 16)});
      exp_q.push_back({1'b0,
        8'h10 + 8'(int'(c) / 16)});
      for (int i = 0; i < w; i++)
        exp_q.push_back({1'b1, (s > 6'd14) ? 8'h00
          : rom(s, r[0], 9'(i))});
    end
  endtask

  task automatic compare_stream(input string nm);
    check({nm, "_len"}, 16'(cap_q.size()),
          16'(exp_q.size()));
    for (int k = 0; k < exp_q.size()
                  && k < cap_q.size(); k++)
      check($sformatf("%s_b%0d", nm, k),
            {7'b0, cap_q[k]}, {7'b0, exp_q[k]});
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_req_ready"}, 16'(bus.req_ready), 16'd1);
    check({nm, "_out_valid"}, 16'(bus.out_valid), 16'd0);
    check({nm, "_out_dc"},    16'(bus.out_dc),    16'd0);
    check({nm, "_out_byte"},  16'(bus.out_byte),  16'd0);
    check({nm, "_font_sel"},  16'(bus.font_sel),  16'd0);
    check({nm, "_font_row"},  16'(bus.font_row),  16'd0);
    check({nm, "_index"},     16'(bus.index),     16'd0);
    check({nm, "_busy"},      16'(bus.busy),      16'd0);
    check({nm, "_done"},      16'(bus.done),      16'd0);
  endtask

  // Issue one request, capture every handshake
  // until done; cycle 0 is the accept cycle.
  task automatic run_req(
    input logic [5:0] s,
    input logic [2:0] p,
    input logic [6:0] c,
    input int         bp,
    input bit         poke
  );
    logic       pv, pr, pdc;
    logic [7:0] pb;
    logic [8:0] pidx;
    cap_q.delete();
    done_cyc = -1;
    pv = 1'b0; pr = 1'b1; pdc = 1'b0;
    pb = 8'h00; pidx = 9'h000;
    @(negedge sys_clk);
    check("ready_before_req", 16'(bus.req_ready), 16'd1);
    bus.req_valid    = 1'b1;
    bus.req_font_sel = s;
    bus.req_page     = p;
    bus.req_col      = c;
    bus.out_ready    = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge sys_clk);
      bus.req_valid = 1'b0;
      if (k == 1)
        check("busy_after_accept", 16'(bus.busy), 16'd1);
      if (poke && k == 10) begin
        check("ready_while_busy",
              16'(bus.req_ready), 16'd0);
        bus.req_valid    = 1'b1;
        bus.req_font_sel = 6'd5;
        bus.req_page     = 3'd1;
      end
      if (bus.done) begin
        done_cyc = k;
        break;
      end
      if (pv && !pr) begin
        check("stall_byte", 16'(bus.out_byte), 16'(pb));
        check("stall_dc", 16'(bus.out_dc), 16'(pdc));
        check("stall_index", 16'(bus.index), 16'(pidx));
      end
      bus.out_ready = (bp == 0)
        || (int'($urandom_range(99)) >= bp);
      if (bus.out_valid && bus.out_ready)
        cap_q.push_back({bus.out_dc, bus.out_byte});
      pv = bus.out_valid; pr = bus.out_ready;
      pb = bus.out_byte; pdc = bus.out_dc;
      pidx = bus.index;
    end
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    if (done_cyc < 0) begin
      check("done_timeout", 16'd0, 16'd1);
    end else begin
      check("busy_at_done", 16'(bus.busy), 16'd0);
      check("ready_at_done", 16'(bus.req_ready), 16'd1);
      @(negedge sys_clk);
      check("done_pulse", 16'(bus.done), 16'd0);
      check("idle_after", 16'(bus.busy), 16'd0);
    end
  endtask

  typedef struct {
    logic [5:0] sel;
    logic [2:0] page;
    logic [6:0] col;
    int         exp_done;
    logic [7:0] pg0;
    logic [7:0] pg1;
  } vec_t;

  vec_t       vecs[5];
  logic [8:0] exp0[38];

  initial begin
    int w;
    int hs;
    logic [5:0] rs;
    logic [2:0] rp;
    logic [6:0] rc;

    vecs[0] = '{6'd0,  3'd2, 7'h25, 39, 8'hB2, 8'hB3};
    vecs[1] = '{6'd11, 3'd7, 7'h00, 71, 8'hB7, 8'hB0};
    vecs[2] = '{6'd20, 3'd3, 7'h7F, 39, 8'hB3, 8'hB4};
    vecs[3] = '{6'd4,  3'd6, 7'h40, 71, 8'hB6, 8'hB7};
    vecs[4] = '{6'd14, 3'd0, 7'h10, 39, 8'hB0, 8'hB1};

    exp0 = '{9'h0B2, 9'h005, 9'h012,
             9'h108, 9'h1F8, 9'h188, 9'h188,
             9'h1E8, 9'h108, 9'h110, 9'h100,
             9'h0B3, 9'h005, 9'h012,
             9'h120, 9'h13F, 9'h120, 9'h100,
             9'h103, 9'h100, 9'h100, 9'h100,
             9'h000, 9'h000, 9'h000, 9'h000,
             9'h000, 9'h000, 9'h000, 9'h000,
             9'h000, 9'h000, 9'h000, 9'h000,
             9'h000, 9'h000, 9'h000, 9'h000};

    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_font_sel = 6'd0;
    bus.req_page     = 3'd0;
    bus.req_col      = 7'd0;
    bus.out_ready    = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge sys_clk);
    check("ready_after_rst", 16'(bus.req_ready), 16'd1);

    for (int v = 0; v < 5; v++) begin
      run_req(vecs[v].sel, vecs[v].page,
              vecs[v].col, 0, 1'b0);
      model(vecs[v].sel, vecs[v].page, vecs[v].col);
      compare_stream($sformatf("vec%0d", v));
      check($sformatf("vec%0d_done_cyc", v),
            16'(done_cyc), 16'(vecs[v].exp_done));
      w = ((vecs[v].exp_done - 1) / 2 - 3) / 2;
      if (cap_q.size() > 3 + w) begin
        check($sformatf("vec%0d_pg0", v),
              {7'b0, cap_q[0]}, {8'b0, vecs[v].pg0});
        check($sformatf("vec%0d_pg1", v),
              {7'b0, cap_q[3 + w]}, {8'b0, vecs[v].pg1});
      end
      if (vecs[v].sel == 6'd11 && cap_q.size() == 38) begin
        check("s11_d0", {7'b0, cap_q[3]},  16'h106);
        check("s11_d1", {7'b0, cap_q[4]},  16'h109);
        check("s11_d2", {7'b0, cap_q[5]},  16'h109);
        check("s11_d3", {7'b0, cap_q[6]},  16'h1E6);
        check("s11_e2", {7'b0, cap_q[35]}, 16'h110);
        check("s11_e1", {7'b0, cap_q[36]}, 16'h100);
        check("s11_e0", {7'b0, cap_q[37]}, 16'h100);
      end
    end

    // backpressure: stream identical to the fixed one
    for (int rep = 0; rep < 2; rep++) begin
      run_req(6'd0, 3'd2, 7'h25, 45, 1'b0);
      exp_q.delete();
      for (int k = 0; k < 22; k++)
        exp_q.push_back(exp0[k]);
      compare_stream($sformatf("bp%0d", rep));
    end

    // random requests against the model
    for (int t = 0; t < 12; t++) begin
      rs = 6'($urandom_range(22));
      rp = 3'($urandom_range(7));
      rc = 7'($urandom_range(127));
      run_req(rs, rp, rc,
              (t % 3 == 0) ? 0 : int'($urandom_range(60)),
              1'b0);
      model(rs, rp, rc);
      compare_stream($sformatf("rnd%0d", t));
    end

    // reset after the 5th handshake
    @(negedge sys_clk);
    bus.req_valid    = 1'b1;
    bus.req_font_sel = 6'd9;
    bus.req_page     = 3'd4;
    bus.req_col      = 7'd3;
    bus.out_ready    = 1'b1;
    hs = 0;
    for (int k = 1; k < 60 && hs < 5; k++) begin
      @(negedge sys_clk);
      bus.req_valid = 1'b0;
      if (bus.out_valid && bus.out_ready) hs++;
    end
    check("hs_before_rst", 16'(hs), 16'd5);
    @(posedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    check_reset("post_rst");

    run_req(6'd0, 3'd2, 7'h25, 0, 1'b1);
    exp_q.delete();
    for (int k = 0; k < 22; k++)
      exp_q.push_back(exp0[k]);
    compare_stream("after_rst");
    check("after_rst_done", 16'(done_cyc), 16'd39);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
